auto_range_freq_ctrl: RTL and testbench

Controller that sequences the frequency-measurement datapath. Each measurement runs in one of two ranges: a 1 s gated edge counter (HF) or the period-based low-frequency counter (LF). The controller picks the range, handles start/ready/done handshakes with both units, and presents one registered result with a valid pulse. It also aborts LF measurements that never complete. It sits between the top-level UI/display logic and the two counter units.

---
 rtl/freq_ctrl_pkg.sv | 31 +++
 rtl/auto_range_freq_ctrl_timeout_timer.sv | 50 +++++
 rtl/auto_range_freq_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_auto_range_freq_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : freq_ctrl_pkg
// Description : Shared types and widths for the auto-ranging frequency
//               measurement controller.
// Revision    : 1.0 - initial release
// ============================================================================
package freq_ctrl_pkg;

  // Width of every frequency value moving through the controller (Hz).
  localparam int FREQ_W = 32;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HF_START = 3'd1,
    HF_WAIT  = 3'd2,
    LF_START = 3'd3,
    LF_WAIT  = 3'd4,
    REPORT   = 3'd5
  } state_t;

  // Measurement range: LF = period-based counter, HF = 1 s gated counter.
  typedef enum logic {
    RANGE_LF = 1'b0,
    RANGE_HF = 1'b1
  } range_t;

endpackage : freq_ctrl_pkg
`default_nettype wire

// File: rtl/auto_range_freq_ctrl_timeout_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : timeout_timer
// Description : Saturating cycle counter that flags when an LF measurement
//               has been waiting TIMEOUT_CYC cycles. Cleared while the
//               controller prepares a new LF start, counts while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module timeout_timer #(
  parameter int TIMEOUT_CYC = 200_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  // Guard against a degenerate 0-bit counter for tiny limits.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, then count up and hold at the terminal value.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable && (count_q != c_last)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Terminal count reached on the cycle the count equals TIMEOUT_CYC - 1.
  assign o_expired = i_enable && (count_q == c_last);

endmodule : timeout_timer
`default_nettype wire

// File: rtl/auto_range_freq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : auto_range_freq_ctrl
// Description : Sequences the HF (gated edge count) and LF (period based)
//               frequency counters, picks the range, and presents a single
//               registered result with a valid pulse.
// Config      : AUTO_RANGE_TIMEOUT_EN - builds the LF_WAIT timeout
//               (o_lf_abort / o_timeout); otherwise both stay at 0.
// Revision    : 1.0 - initial release
// ============================================================================
module auto_range_freq_ctrl
  import freq_ctrl_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int THRESH_HZ   = 1000,
  parameter int TIMEOUT_CYC = 200_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_continuous,
  output logic              o_busy,
  output logic              o_hf_start,
  input  logic              i_hf_done,
  input  logic [FREQ_W-1:0] i_hf_count,
  output logic              o_lf_start,
  input  logic              i_lf_ready,
  input  logic              i_lf_done,
  input  logic [FREQ_W-1:0] i_lf_frequency,
  output logic              o_lf_abort,
  output logic [FREQ_W-1:0] o_frequency,
  output logic              o_range,
  output logic              o_valid,
  output logic              o_timeout
);

  localparam logic [FREQ_W-1:0] c_thresh = FREQ_W'(THRESH_HZ);

  state_t              state_q,     state_d;
  range_t              sticky_q,    sticky_d;     // range the next measurement starts in
  logic [FREQ_W-1:0]   result_q,    result_d;     // value waiting to be reported
  range_t              res_range_q, res_range_d;
  logic                tflag_q,     tflag_d;      // pending result came from a timeout
  logic [FREQ_W-1:0]   freq_q,      freq_d;
  range_t              range_q,     range_d;
  logic                valid_q,     valid_d;
  logic                timeout_q,   timeout_d;
  logic                hf_start_q,  hf_start_d;
  logic                lf_start_q,  lf_start_d;
  logic                abort_q,     abort_d;
  logic                busy_q,      busy_d;

  logic                timer_expired;

  // CLK_FREQ only documents the clock; TIMEOUT_CYC is unused when the
  // timeout is not built. Both are folded here so neither reads as dead.
  logic unused_cfg;
  assign unused_cfg = (CLK_FREQ > 0) ^ (TIMEOUT_CYC > 0);

`ifdef AUTO_RANGE_TIMEOUT_EN
  timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (state_q == LF_START),
    .i_enable  (state_q == LF_WAIT),
    .o_expired (timer_expired)
  );
`else
  // No timer: LF_WAIT waits for i_lf_done indefinitely, so the abort and
  // timeout flops never set and those outputs stay at 0.
  assign timer_expired = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    sticky_d    = sticky_q;
    result_d    = result_q;
    res_range_d = res_range_q;
    tflag_d     = tflag_q;
    freq_d      = freq_q;
    range_d     = range_q;
    valid_d     = 1'b0;
    timeout_d   = 1'b0;
    hf_start_d  = 1'b0;
    lf_start_d  = 1'b0;
    abort_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start || i_continuous) begin
          state_d = (sticky_q == RANGE_HF) ? HF_START : LF_START;
        end
      end

      HF_START: begin
        hf_start_d = 1'b1;
        state_d    = HF_WAIT;
      end

      HF_WAIT: begin
        if (i_hf_done) begin
          if (i_hf_count >= c_thresh) begin
            result_d    = i_hf_count;
            res_range_d = RANGE_HF;
            tflag_d     = 1'b0;
            state_d     = REPORT;
          end else begin
            // Too slow for the gated counter: retry in LF without reporting.
            sticky_d = RANGE_LF;
            state_d  = LF_START;
          end
        end
      end

      LF_START: begin
        if (i_lf_ready) begin
          lf_start_d = 1'b1;
          state_d    = LF_WAIT;
        end
      end

      LF_WAIT: begin
        // A done on the terminal-count cycle takes priority over the abort.
        if (i_lf_done) begin
          result_d    = i_lf_frequency;
          res_range_d = RANGE_LF;
          tflag_d     = 1'b0;
          if (i_lf_frequency >= c_thresh) begin
            sticky_d = RANGE_HF;
          end
          state_d = REPORT;
        end else if (timer_expired) begin
          abort_d     = 1'b1;
          result_d    = '0;
          res_range_d = RANGE_LF;
          tflag_d     = 1'b1;
          state_d     = REPORT;
        end
      end

      REPORT: begin
        freq_d    = result_q;
        range_d   = res_range_q;
        valid_d   = 1'b1;
        timeout_d = tflag_q;
        if (i_continuous) begin
          state_d = (sticky_q == RANGE_HF) ? HF_START : LF_START;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      sticky_q    <= RANGE_HF;
      result_q    <= '0;
      res_range_q <= RANGE_HF;
      tflag_q     <= 1'b0;
      freq_q      <= '0;
      range_q     <= RANGE_HF;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      hf_start_q  <= 1'b0;
      lf_start_q  <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sticky_q    <= sticky_d;
      result_q    <= result_d;
      res_range_q <= res_range_d;
      tflag_q     <= tflag_d;
      freq_q      <= freq_d;
      range_q     <= range_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      hf_start_q  <= hf_start_d;
      lf_start_q  <= lf_start_d;
      abort_q     <= abort_d;
      busy_q      <= busy_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_hf_start  = hf_start_q;
  assign o_lf_start  = lf_start_q;
  assign o_lf_abort  = abort_q;
  assign o_frequency = freq_q;
  assign o_range     = range_q;
  assign o_valid     = valid_q;
  assign o_timeout   = timeout_q;

endmodule : auto_range_freq_ctrl
`default_nettype wire

// File: tb/tb_auto_range_freq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_auto_range_freq_ctrl
// Description : Directed bench for auto_range_freq_ctrl with fixed-latency
//               HF/LF counter mocks (THRESH_HZ = 1000, TIMEOUT_CYC = 1000).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_auto_range_freq_ctrl;

  localparam int HF_LAT = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, continuous;
  logic        busy, hf_start, lf_start, lf_abort;
  logic        hf_done, lf_done, lf_ready;
  logic [31:0] hf_count, lf_freq, frequency;
  logic        range_o, valid, timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // observation log
  int cyc = 0;
  int valid_cnt = 0, valid_cyc = 0, hf_starts = 0, hf_start_cyc = 0;
  int lf_starts = 0, lf_start_cyc = 0, aborts = 0, abort_cyc = 0;
  int hf_done_cyc = 0, lf_done_cyc = 0, start_cyc = 0;
  logic [31:0] last_freq = '0;
  logic        last_range = 1'b0, last_tmo = 1'b0;

  // mock state
  int hf_cd = 0, lf_cd = 0, lf_lat = 8;
  bit lf_hang = 0;
  logic [31:0] hf_value = '0, lf_value = '0;

  auto_range_freq_ctrl #(
    .CLK_FREQ    (100_000_000),
    .THRESH_HZ   (1000),
    .TIMEOUT_CYC (1000)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_continuous   (continuous),
    .o_busy         (busy),
    .o_hf_start     (hf_start),
    .i_hf_done      (hf_done),
    .i_hf_count     (hf_count),
    .o_lf_start     (lf_start),
    .i_lf_ready     (lf_ready),
    .i_lf_done      (lf_done),
    .i_lf_frequency (lf_freq),
    .o_lf_abort     (lf_abort),
    .o_frequency    (frequency),
    .o_range        (range_o),
    .o_valid        (valid),
    .o_timeout      (timeout)
  );

  always #5 clk = ~clk;

  // One clock: observe outputs 1 ns after the edge, then advance the mocks.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (valid) begin
      valid_cnt++; valid_cyc = cyc;
      last_freq = frequency; last_range = range_o; last_tmo = timeout;
    end
    if (hf_start) begin hf_starts++; hf_start_cyc = cyc; end
    if (lf_start) begin lf_starts++; lf_start_cyc = cyc; end
    if (lf_abort) begin aborts++; abort_cyc = cyc; end
    hf_done = 1'b0;
    lf_done = 1'b0;
    if (hf_cd > 0) begin
      hf_cd--;
      if (hf_cd == 0) begin hf_done = 1'b1; hf_count = hf_value; hf_done_cyc = cyc; end
    end
    if (hf_start) hf_cd = HF_LAT;
    if (lf_cd > 0) begin
      lf_cd--;
      if (lf_cd == 0) begin lf_done = 1'b1; lf_freq = lf_value; lf_done_cyc = cyc; end
    end
    if (lf_start && !lf_hang) lf_cd = lf_lat;
    if (lf_abort) lf_cd = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int v0;
    v0 = valid_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (valid_cnt != v0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; hf_done = 1'b0; lf_done = 1'b0;
    lf_ready = 1'b1; hf_count = '0; lf_freq = '0;
    repeat (3) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (hf_start !== 1'b0) begin n_fail++; $display("FAIL reset_hf_start: got %b want 0", hf_start); end
    n_checks++; if (lf_start !== 1'b0) begin n_fail++; $display("FAIL reset_lf_start: got %b want 0", lf_start); end
    n_checks++; if (lf_abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b want 0", lf_abort); end
    n_checks++; if (frequency !== 32'd0) begin n_fail++; $display("FAIL reset_freq: got %0d want 0", frequency); end
    n_checks++; if (range_o !== 1'b1) begin n_fail++; $display("FAIL reset_range: got %b want 1", range_o); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_hf();
    bit ok; int v0, ls0;
    hf_value = 32'd50_000; v0 = valid_cnt; ls0 = lf_starts;
    pulse_start();
    wait_valid(50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL hf_valid_seen: got none want one within 50 cycles"); end
    n_checks++; if (hf_start_cyc !== start_cyc + 1) begin n_fail++; $display("FAIL hf_start_latency: got cycle %0d want %0d", hf_start_cyc, start_cyc + 1); end
    n_checks++; if (valid_cyc !== hf_done_cyc + 2) begin n_fail++; $display("FAIL hf_valid_latency: got cycle %0d want %0d", valid_cyc, hf_done_cyc + 2); end
    n_checks++; if (last_freq !== 32'd50_000) begin n_fail++; $display("FAIL hf_freq: got %0d want 50000", last_freq); end
    n_checks++; if (last_range !== 1'b1) begin n_fail++; $display("FAIL hf_range: got %b want 1", last_range); end
    repeat (10) tick();
    n_checks++; if (valid_cnt !== v0 + 1) begin n_fail++; $display("FAIL hf_valid_count: got %0d want %0d", valid_cnt - v0, 1); end
    n_checks++; if (lf_starts !== ls0) begin n_fail++; $display("FAIL hf_no_lf_start: got %0d lf starts want 0", lf_starts - ls0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hf_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_hf_to_lf();
    bit ok; int v0, hs0, ls0;
    hf_value = 32'd12; lf_value = 32'd12; lf_lat = 8;
    v0 = valid_cnt; hs0 = hf_starts; ls0 = lf_starts;
    pulse_start();
    wait_valid(80, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL h2l_valid_seen: got none want one within 80 cycles"); end
    n_checks++; if (hf_starts !== hs0 + 1 || lf_starts !== ls0 + 1) begin n_fail++; $display("FAIL h2l_starts: got hf %0d lf %0d want 1 1", hf_starts - hs0, lf_starts - ls0); end
    n_checks++; if (lf_start_cyc <= hf_start_cyc) begin n_fail++; $display("FAIL h2l_order: got lf at %0d hf at %0d want lf after hf", lf_start_cyc, hf_start_cyc); end
    n_checks++; if (last_freq !== 32'd12 || last_range !== 1'b0) begin n_fail++; $display("FAIL h2l_result: got %0d range %b want 12 range 0", last_freq, last_range); end
    repeat (5) tick();
    n_checks++; if (valid_cnt !== v0 + 1) begin n_fail++; $display("FAIL h2l_valid_count: got %0d want 1", valid_cnt - v0); end
    hs0 = hf_starts;
    pulse_start();
    wait_valid(80, ok);
    n_checks++; if (lf_start_cyc !== start_cyc + 1) begin n_fail++; $display("FAIL sticky_lf_start: got cycle %0d want %0d", lf_start_cyc, start_cyc + 1); end
    n_checks++; if (hf_starts !== hs0) begin n_fail++; $display("FAIL sticky_lf_no_hf: got %0d hf starts want 0", hf_starts - hs0); end
    n_checks++; if (valid_cyc !== lf_done_cyc + 2) begin n_fail++; $display("FAIL lf_valid_latency: got cycle %0d want %0d", valid_cyc, lf_done_cyc + 2); end
  endtask

  task automatic test_lf_to_hf();
    bit ok; int ls0;
    lf_value = 32'd1500;
    pulse_start();
    wait_valid(60, ok);
    n_checks++; if (!ok || last_freq !== 32'd1500 || last_range !== 1'b0) begin n_fail++; $display("FAIL l2h_result: got %0d range %b ok %b want 1500 range 0", last_freq, last_range, ok); end
    repeat (3) tick();
    hf_value = 32'd50_000; ls0 = lf_starts;
    pulse_start();
    wait_valid(60, ok);
    n_checks++; if (hf_start_cyc !== start_cyc + 1) begin n_fail++; $display("FAIL l2h_hf_first: got hf start cycle %0d want %0d", hf_start_cyc, start_cyc + 1); end
    n_checks++; if (lf_starts !== ls0) begin n_fail++; $display("FAIL l2h_no_lf: got %0d lf starts want 0", lf_starts - ls0); end
    n_checks++; if (!ok || last_freq !== 32'd50_000 || last_range !== 1'b1) begin n_fail++; $display("FAIL l2h_hf_result: got %0d range %b want 50000 range 1", last_freq, last_range); end
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    bit ok; int v0, ls0, a0;
    hf_value = 32'd12; lf_hang = 1'b1;
    v0 = valid_cnt; ls0 = lf_starts; a0 = aborts;
    pulse_start();
`ifdef AUTO_RANGE_TIMEOUT_EN
    wait_valid(1200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo_valid_seen: got none want one within 1200 cycles"); end
    n_checks++; if (aborts !== a0 + 1) begin n_fail++; $display("FAIL tmo_abort_count: got %0d want 1", aborts - a0); end
    n_checks++; if (abort_cyc - lf_start_cyc !== 1000) begin n_fail++; $display("FAIL tmo_abort_time: got %0d cycles in LF_WAIT want 1000", abort_cyc - lf_start_cyc); end
    n_checks++; if (valid_cyc !== abort_cyc + 1) begin n_fail++; $display("FAIL tmo_valid_time: got cycle %0d want %0d", valid_cyc, abort_cyc + 1); end
    n_checks++; if (last_tmo !== 1'b1 || last_freq !== 32'd0 || last_range !== 1'b0) begin n_fail++; $display("FAIL tmo_result: got tmo %b freq %0d range %b want 1 0 0", last_tmo, last_freq, last_range); end
    lf_hang = 1'b0;
`else
    repeat (1100) tick();
    n_checks++; if (valid_cnt !== v0 || busy !== 1'b1) begin n_fail++; $display("FAIL notmo_wait: got valids %0d busy %b want 0 1", valid_cnt - v0, busy); end
    n_checks++; if (aborts !== a0 || lf_starts !== ls0 + 1) begin n_fail++; $display("FAIL notmo_abort: got aborts %0d lf starts %0d want 0 1", aborts - a0, lf_starts - ls0); end
    lf_hang = 1'b0;
    lf_freq = 32'd7; lf_done = 1'b1;
    wait_valid(5, ok);
    n_checks++; if (!ok || last_freq !== 32'd7 || last_tmo !== 1'b0 || last_range !== 1'b0) begin n_fail++; $display("FAIL notmo_late_done: got %0d tmo %b range %b want 7 0 0", last_freq, last_tmo, last_range); end
`endif
    repeat (3) tick();
  endtask

  task automatic test_done_vs_timeout();
    bit ok; int a0;
    lf_value = 32'd250; lf_lat = 999; a0 = aborts;
    pulse_start();
    wait_valid(1200, ok);
    n_checks++; if (!ok || last_freq !== 32'd250) begin n_fail++; $display("FAIL dvt_result: got %0d ok %b want 250", last_freq, ok); end
    n_checks++; if (lf_done_cyc - lf_start_cyc !== 999) begin n_fail++; $display("FAIL dvt_setup: got done %0d cycles into LF_WAIT want 999", lf_done_cyc - lf_start_cyc); end
    n_checks++; if (aborts !== a0 || last_tmo !== 1'b0) begin n_fail++; $display("FAIL dvt_no_abort: got aborts %0d tmo %b want 0 0", aborts - a0, last_tmo); end
    lf_lat = 8;
    repeat (3) tick();
  endtask

  task automatic test_lf_ready();
    bit ok; int ls0, r;
    lf_value = 32'd20; ls0 = lf_starts;
    lf_ready = 1'b0;
    pulse_start();
    repeat (50) tick();
    n_checks++; if (lf_starts !== ls0 || busy !== 1'b1) begin n_fail++; $display("FAIL rdy_hold: got lf starts %0d busy %b want 0 1", lf_starts - ls0, busy); end
    lf_ready = 1'b1;
    tick();
    r = cyc;
    wait_valid(40, ok);
    n_checks++; if (lf_start_cyc !== r || lf_starts !== ls0 + 1) begin n_fail++; $display("FAIL rdy_start: got cycle %0d count %0d want %0d 1", lf_start_cyc, lf_starts - ls0, r); end
    n_checks++; if (!ok || last_freq !== 32'd20) begin n_fail++; $display("FAIL rdy_result: got %0d ok %b want 20", last_freq, ok); end
    repeat (3) tick();
  endtask

  task automatic test_continuous();
    int v0, gaps; bit seen, dropped;
    lf_value = 32'd30; v0 = valid_cnt; gaps = 0; seen = 1'b0; dropped = 1'b0;
    continuous = 1'b1;
    for (int i = 0; i < 400 && valid_cnt < v0 + 3; i++) begin
      tick();
      if (!dropped && valid_cnt == v0 + 2) begin continuous = 1'b0; dropped = 1'b1; end
      if (valid_cnt < v0 + 3) begin
        if (busy) seen = 1'b1;
        else if (seen) gaps++;
      end
    end
    continuous = 1'b0;
    repeat (20) tick();
    n_checks++; if (valid_cnt !== v0 + 3) begin n_fail++; $display("FAIL cont_count: got %0d valids want 3", valid_cnt - v0); end
    n_checks++; if (gaps !== 0) begin n_fail++; $display("FAIL cont_no_idle: got %0d idle cycles want 0", gaps); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_busy_falls: got %b want 0", busy); end
    n_checks++; if (last_freq !== 32'd30 || last_range !== 1'b0) begin n_fail++; $display("FAIL cont_result: got %0d range %b want 30 0", last_freq, last_range); end
  endtask

  task automatic test_stray();
    bit ok; int v0, hs0, ls0;
    v0 = valid_cnt; hs0 = hf_starts; ls0 = lf_starts;
    hf_count = 32'd5000; hf_done = 1'b1; lf_freq = 32'd9999; lf_done = 1'b1;
    repeat (4) tick();
    n_checks++; if (valid_cnt !== v0 || busy !== 1'b0) begin n_fail++; $display("FAIL stray_idle: got valids %0d busy %b want 0 0", valid_cnt - v0, busy); end
    n_checks++; if (hf_starts !== hs0 || lf_starts !== ls0) begin n_fail++; $display("FAIL stray_idle_starts: got hf %0d lf %0d want 0 0", hf_starts - hs0, lf_starts - ls0); end
    lf_value = 32'd44;
    pulse_start();
    repeat (3) tick();
    start = 1'b1; hf_count = 32'd5000; hf_done = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(40, ok);
    repeat (10) tick();
    n_checks++; if (!ok || last_freq !== 32'd44 || last_range !== 1'b0) begin n_fail++; $display("FAIL stray_busy_result: got %0d range %b want 44 0", last_freq, last_range); end
    n_checks++; if (valid_cnt !== v0 + 1 || lf_starts !== ls0 + 1 || hf_starts !== hs0) begin n_fail++; $display("FAIL stray_busy_counts: got valids %0d lf %0d hf %0d want 1 1 0", valid_cnt - v0, lf_starts - ls0, hf_starts - hs0); end
  endtask

  task automatic test_reset_mid();
    bit ok; int ls0;
    lf_hang = 1'b1; ls0 = lf_starts;
    pulse_start();
    for (int i = 0; i < 20 && lf_starts == ls0; i++) tick();
    repeat (5) tick();
    n_checks++; if (busy !== 1'b1 || lf_starts !== ls0 + 1) begin n_fail++; $display("FAIL rmid_in_wait: got busy %b lf starts %0d want 1 1", busy, lf_starts - ls0); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || valid !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL rmid_flags: got busy %b valid %b tmo %b want 0 0 0", busy, valid, timeout); end
    n_checks++; if (hf_start !== 1'b0 || lf_start !== 1'b0 || lf_abort !== 1'b0) begin n_fail++; $display("FAIL rmid_pulses: got %b %b %b want 0 0 0", hf_start, lf_start, lf_abort); end
    n_checks++; if (frequency !== 32'd0 || range_o !== 1'b1) begin n_fail++; $display("FAIL rmid_result: got %0d range %b want 0 1", frequency, range_o); end
    repeat (2) tick();
    lf_hang = 1'b0; lf_cd = 0; hf_cd = 0;
    rst_n = 1'b1;
    tick();
    hf_value = 32'd50_000;
    pulse_start();
    wait_valid(50, ok);
    n_checks++; if (hf_start_cyc !== start_cyc + 1 || !ok || last_range !== 1'b1) begin n_fail++; $display("FAIL rmid_restart_hf: got hf start %0d ok %b range %b want %0d 1 1", hf_start_cyc, ok, last_range, start_cyc + 1); end
  endtask

  initial begin
    test_reset();
    test_hf();
    test_hf_to_lf();
    test_lf_to_hf();
    test_timeout();
    test_done_vs_timeout();
    test_lf_ready();
    test_continuous();
    test_stray();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_auto_range_freq_ctrl
`default_nettype wire
